// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the Project 4 CPU control sequencer.
// Holds the top-level opcode encodings, the 3-bit ALU opcode names,
// the sequencer state encoding, the instruction field bit positions and
// a small helper that tells which ALU operations produce a meaningful carry.
package cpu_pkg;

  // Top-level opcodes (instruction bits [15:12]); 0xxx are ALU operations
  localparam logic [3:0] OP_LDI  = 4'b1000;
  localparam logic [3:0] OP_BZ   = 4'b1001;
  localparam logic [3:0] OP_BC   = 4'b1010;
  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU OpCode values driven on alu_opcode
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  // Instruction field bit positions
  localparam int F_OP_HI  = 15;
  localparam int F_OP_LO  = 12;
  localparam int F_RD_HI  = 11;
  localparam int F_RD_LO  = 9;
  localparam int F_RA_HI  = 8;
  localparam int F_RA_LO  = 6;
  localparam int F_RB_HI  = 5;
  localparam int F_RB_LO  = 3;
  localparam int F_IMM_HI = 7;
  localparam int F_IMM_LO = 0;

  // Only add and subtract define the carry; the other ALU ops leave flag_c alone
  function automatic logic sets_carry(input logic [2:0] alu_op);
    return (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
  endfunction

endpackage

// File: rtl/cpu_pc.sv
// cpu_pc: program counter register for the control sequencer.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset, loads RESET_PC
//   restart - restart from HALT, also loads RESET_PC
//   load    - load target (taken branch / jump)
//   inc     - advance by one, wrapping modulo 2^PC_W
//   target  - branch/jump destination
//   pc      - current program counter
module cpu_pc #(
  parameter int             PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  // Restart shares the reset value; load wins over increment, and the
  // natural overflow of the adder gives the wrap from all-ones to zero
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute/writeback sequencer that sits
// in front of the 8-bit ALU. It drives the ALU OpCode and the register-file
// addresses/enables and keeps the architectural zero/carry flags.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - begins execution from IDLE, or restarts from HALT
//   imem_addr/rd      - instruction fetch address (= PC) and request
//   imem_data/valid   - instruction word and fetch acknowledge
//   rf_ra/rb_addr     - register read addresses feeding the ALU
//   rf_wr_addr/en/sel - register write address, one-cycle strobe, source select
//   imm_out           - LDI immediate
//   alu_opcode        - ALU OpCode
//   alu_zero/carry    - ALU status inputs
//   flag_z/flag_c     - architectural flags
//   busy/halted       - status
//   illegal_op        - only with CPU_CTRL_TRAP_EN: reserved opcode trapped
// Build option: define CPU_CTRL_TRAP_EN to halt on reserved opcodes instead
// of treating them as no-ops.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int             PC_W     = 8,
  parameter int             INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  output logic [2:0]         rf_ra_addr,
  output logic [2:0]         rf_rb_addr,
  output logic [2:0]         rf_wr_addr,
  output logic               rf_wr_en,
  output logic               rf_wr_sel,
  output logic [7:0]         imm_out,
  output logic [2:0]         alu_opcode,
  input  logic               alu_zero,
  input  logic               alu_carry,
  output logic               flag_z,
  output logic               flag_c,
  output logic               busy,
`ifdef CPU_CTRL_TRAP_EN
  output logic               illegal_op,
`endif
  output logic               halted
);

  state_e             state;
  state_e             state_next;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         op;
  logic               ir_load;
  logic               upd_z;
  logic               upd_c;
  logic               restart;
  logic               pc_load;
  logic               pc_inc;
`ifdef CPU_CTRL_TRAP_EN
  logic               trap_set;
`endif

  assign op = ir[F_OP_HI:F_OP_LO];

  cpu_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .load    (pc_load),
    .inc     (pc_inc),
    .target  (PC_W'(ir[F_IMM_HI:F_IMM_LO])),
    .pc      (imem_addr)
  );

  // State, instruction register and flags. Branches read the flags before
  // this edge, so they always see the result of the previous instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_next;
      if (ir_load) begin
        ir <= imem_data;
      end
      if (restart) begin
        flag_z <= 1'b0;
        flag_c <= 1'b0;
      end else begin
        if (upd_z) begin
          flag_z <= alu_zero;
        end
        if (upd_c) begin
          flag_c <= alu_carry;
        end
      end
    end
  end

`ifdef CPU_CTRL_TRAP_EN
  // Sticky trap indicator, held through HALT until reset or restart
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      illegal_op <= 1'b0;
    end else if (trap_set) begin
      illegal_op <= 1'b1;
    end
  end
`endif

  // Next state, PC control and all decoded outputs. Register addresses and
  // ALU opcode are held from DECODE through WB so the ALU inputs stay stable.
  always_comb begin
    state_next = state;
    ir_load    = 1'b0;
    upd_z      = 1'b0;
    upd_c      = 1'b0;
    restart    = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
`ifdef CPU_CTRL_TRAP_EN
    trap_set   = 1'b0;
`endif
    imem_rd    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    rf_wr_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_sel  = 1'b0;
    imm_out    = '0;
    alu_opcode = '0;

    if (state == S_DECODE || state == S_EXEC || state == S_WB) begin
      rf_ra_addr = ir[F_RA_HI:F_RA_LO];
      rf_rb_addr = ir[F_RB_HI:F_RB_LO];
      alu_opcode = op[2:0];
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_rd = 1'b1;
        if (imem_valid) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (!op[3]) begin
          upd_z      = 1'b1;
          upd_c      = sets_carry(op[2:0]);
          state_next = S_WB;
        end else begin
          case (op)
            OP_LDI: begin
              state_next = S_WB;
            end
            OP_BZ: begin
              pc_load    = flag_z;
              pc_inc     = !flag_z;
              state_next = S_FETCH;
            end
            OP_BC: begin
              pc_load    = flag_c;
              pc_inc     = !flag_c;
              state_next = S_FETCH;
            end
            OP_JMP: begin
              pc_load    = 1'b1;
              state_next = S_FETCH;
            end
            OP_HALT: begin
              state_next = S_HALT;
            end
            default: begin
`ifdef CPU_CTRL_TRAP_EN
              trap_set   = 1'b1;
              state_next = S_HALT;
`else
              pc_inc     = 1'b1;
              state_next = S_FETCH;
`endif
            end
          endcase
        end
      end
      S_WB: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = ir[F_RD_HI:F_RD_LO];
        rf_wr_sel  = (op == OP_LDI);
        if (op == OP_LDI) begin
          imm_out = ir[F_IMM_HI:F_IMM_LO];
        end
        pc_inc     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          restart    = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: self-checking bench for cpu_ctrl. An instruction-level model
// tracks PC, flags and where each instruction is in its cycle budget
// (4 cycles for ALU/LDI, 3 for branches/HALT/reserved, plus fetch stalls);
// every cycle the DUT outputs are compared against it. Directed programs
// add literal expectations that pin the model.
module tb_cpu_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [2:0]  rf_ra_addr;
  logic [2:0]  rf_rb_addr;
  logic [2:0]  rf_wr_addr;
  logic        rf_wr_en;
  logic        rf_wr_sel;
  logic [7:0]  imm_out;
  logic [2:0]  alu_opcode;
  logic        alu_zero;
  logic        alu_carry;
  logic        flag_z;
  logic        flag_c;
  logic        busy;
  logic        halted;
`ifdef CPU_CTRL_TRAP_EN
  logic        illegal_op;
`endif

  cpu_ctrl #(
    .PC_W     (8),
    .INSTR_W  (16),
    .RESET_PC (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_sel  (rf_wr_sel),
    .imm_out    (imm_out),
    .alu_opcode (alu_opcode),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .busy       (busy),
`ifdef CPU_CTRL_TRAP_EN
    .illegal_op (illegal_op),
`endif
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory plus per-address ALU status the stub ALU reports
  logic [15:0] imem [256];
  logic        zmem [256];
  logic        cmem [256];
  int          fetch_wait;
  int          block_addr;
  logic        spurious;
  int          wait_cnt;
  logic        check_en;
  int          tests_run;
  int          tests_failed;

  // PC stays on the current instruction until its last cycle, so the stub
  // ALU can key its status on the fetch address
  assign alu_zero  = zmem[imem_addr];
  assign alu_carry = cmem[imem_addr];

  // Instruction memory responder with configurable stall and blocked address
  always begin
    @(posedge clk);
    #1;
    if (imem_rd) begin
      if (int'(imem_addr) != block_addr && wait_cnt >= fetch_wait) begin
        imem_valid = 1'b1;
        imem_data  = imem[imem_addr];
        wait_cnt   = 0;
      end else begin
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        wait_cnt   = wait_cnt + 1;
      end
    end else begin
      imem_valid = spurious;
      imem_data  = 16'hF000;
      wait_cnt   = 0;
    end
  end

  // Instruction-level reference model
  int          m_mode = M_IDLE;
  logic [7:0]  m_pc   = 8'h00;
  logic        m_z    = 1'b0;
  logic        m_c    = 1'b0;
  logic        m_ill  = 1'b0;
  logic [15:0] m_ir   = 16'h0000;
  int          m_cnt  = 0;
  logic [3:0]  m_op;
  logic        m_taken;

  assign m_op    = m_ir[15:12];
  assign m_taken = (m_op == 4'hB) || (m_op == 4'h9 && m_z) || (m_op == 4'hA && m_c);

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= M_IDLE;
      m_pc   <= 8'h00;
      m_z    <= 1'b0;
      m_c    <= 1'b0;
      m_ill  <= 1'b0;
      m_cnt  <= 0;
    end else if (m_mode == M_IDLE) begin
      if (start) begin
        m_mode <= M_RUN;
        m_cnt  <= 0;
      end
    end else if (m_mode == M_HALT) begin
      if (start) begin
        m_mode <= M_RUN;
        m_pc   <= 8'h00;
        m_z    <= 1'b0;
        m_c    <= 1'b0;
        m_ill  <= 1'b0;
        m_cnt  <= 0;
      end
    end else if (m_cnt == 0) begin
      if (imem_valid) begin
        m_ir  <= imem_data;
        m_cnt <= 1;
      end
    end else if (m_cnt == 1) begin
      m_cnt <= 2;
    end else if (m_cnt == 2) begin
      if (!m_op[3]) begin
        m_z <= alu_zero;
        if (m_op[2:1] == 2'b00) m_c <= alu_carry;
        m_cnt <= 3;
      end else if (m_op == 4'h8) begin
        m_cnt <= 3;
      end else if (m_op == 4'h9 || m_op == 4'hA || m_op == 4'hB) begin
        m_pc  <= m_taken ? m_ir[7:0] : m_pc + 8'd1;
        m_cnt <= 0;
      end else if (m_op == 4'hF) begin
        m_mode <= M_HALT;
        m_cnt  <= 0;
      end else begin
`ifdef CPU_CTRL_TRAP_EN
        m_mode <= M_HALT;
        m_ill  <= 1'b1;
`else
        m_pc   <= m_pc + 8'd1;
`endif
        m_cnt  <= 0;
      end
    end else begin
      m_pc  <= m_pc + 8'd1;
      m_cnt <= 0;
    end
  end

  logic e_run;
  logic e_dec;
  logic e_wb;
  logic e_ldi;
  assign e_run = (m_mode == M_RUN);
  assign e_dec = e_run && (m_cnt != 0);
  assign e_wb  = e_run && (m_cnt == 3);
  assign e_ldi = (m_op == 4'h8);

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("imem_addr",  16'(imem_addr),  16'(m_pc));
      checkOutput("imem_rd",    16'(imem_rd),    16'(e_run && m_cnt == 0));
      checkOutput("busy",       16'(busy),       16'(e_run));
      checkOutput("halted",     16'(halted),     16'(m_mode == M_HALT));
      checkOutput("rf_ra_addr", 16'(rf_ra_addr), 16'(e_dec ? m_ir[8:6] : 3'd0));
      checkOutput("rf_rb_addr", 16'(rf_rb_addr), 16'(e_dec ? m_ir[5:3] : 3'd0));
      checkOutput("alu_opcode", 16'(alu_opcode), 16'(e_dec ? m_ir[14:12] : 3'd0));
      checkOutput("rf_wr_en",   16'(rf_wr_en),   16'(e_wb));
      checkOutput("rf_wr_addr", 16'(rf_wr_addr), 16'(e_wb ? m_ir[11:9] : 3'd0));
      checkOutput("rf_wr_sel",  16'(rf_wr_sel),  16'(e_wb && e_ldi));
      checkOutput("imm_out",    16'(imm_out),    16'((e_wb && e_ldi) ? m_ir[7:0] : 8'd0));
      checkOutput("flag_z",     16'(flag_z),     16'(m_z));
      checkOutput("flag_c",     16'(flag_c),     16'(m_c));
`ifdef CPU_CTRL_TRAP_EN
      checkOutput("illegal_op", 16'(illegal_op), 16'(m_ill));
`endif
    end
  end

  // Observation counters used by the literal checks
  int         wr_count;
  logic [2:0] last_wr_addr;
  logic       last_wr_sel;
  logic [7:0] last_imm;
  int         busy_count;
  int         rd_ff_count;

  always @(negedge clk) begin
    if (rf_wr_en) begin
      wr_count     = wr_count + 1;
      last_wr_addr = rf_wr_addr;
      last_wr_sel  = rf_wr_sel;
      last_imm     = imm_out;
    end
    if (busy) busy_count = busy_count + 1;
    if (imem_rd && imem_addr == 8'hFF) rd_ff_count = rd_ff_count + 1;
  end

  // One cycle of reset and/or start, held across exactly one rising edge
  task automatic applyStimulus(input logic do_reset, input logic do_start);
    @(posedge clk);
    #1;
    rst   = do_reset;
    start = do_start;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hF000;
      zmem[i] = 1'b0;
      cmem[i] = 1'b0;
    end
    wr_count    = 0;
    busy_count  = 0;
    rd_ff_count = 0;
  endtask

  task automatic waitHalt(input int max_cycles);
    int n;
    n = 0;
    while (!halted && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("halt_reached", 16'(halted), 16'd1);
  endtask

  task automatic waitFetchAt(input logic [7:0] addr, input int max_cycles);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    while (!found && n < max_cycles) begin
      @(negedge clk);
      found = imem_rd && (imem_addr == addr);
      n++;
    end
    checkOutput("fetch_reached", 16'(found), 16'd1);
  endtask

  task automatic runFresh();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    imem_valid   = 1'b0;
    imem_data    = 16'h0000;
    fetch_wait   = 0;
    block_addr   = -1;
    spurious     = 1'b0;
    wait_cnt     = 0;
    check_en     = 1'b0;
    tests_run    = 0;
    tests_failed = 0;
    last_wr_addr = 3'd0;
    last_wr_sel  = 1'b0;
    last_imm     = 8'd0;
    clearMem();
    @(posedge clk);
    #1;
    check_en = 1'b1;

    // Reset state
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("rst_imem_addr", 16'(imem_addr), 16'h00);
    checkOutput("rst_busy",      16'(busy),      16'd0);
    checkOutput("rst_flags",     16'({flag_z, flag_c}), 16'd0);
    checkOutput("rst_wr_en",     16'(rf_wr_en),  16'd0);

    // ADD with carry; spurious acknowledges and a start while busy are ignored
    clearMem();
    imem[0]  = 16'h0288;
    cmem[0]  = 1'b1;
    spurious = 1'b1;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitHalt(40);
    spurious = 1'b0;
    checkOutput("add_flag_c",   16'(flag_c),       16'd1);
    checkOutput("add_flag_z",   16'(flag_z),       16'd0);
    checkOutput("add_wr_count", 16'(wr_count),     16'd1);
    checkOutput("add_wr_addr",  16'(last_wr_addr), 16'd1);
    checkOutput("add_halt_pc",  16'(imem_addr),    16'h01);
    checkOutput("add_busy_cyc", 16'(busy_count),   16'd7);

    // SUB sets carry, AND keeps it while zero follows the ALU
    clearMem();
    imem[0] = 16'h1000;
    cmem[0] = 1'b1;
    imem[1] = 16'h2000;
    zmem[1] = 1'b1;
    runFresh();
    waitHalt(40);
    checkOutput("hold_flag_c",  16'(flag_c),    16'd1);
    checkOutput("hold_flag_z",  16'(flag_z),    16'd1);
    checkOutput("hold_halt_pc", 16'(imem_addr), 16'h02);

    // BZ taken
    clearMem();
    imem[0] = 16'h2000;
    zmem[0] = 1'b1;
    imem[1] = 16'h9040;
    runFresh();
    waitHalt(40);
    checkOutput("bz_taken_pc", 16'(imem_addr), 16'h40);
    checkOutput("bz_wr_count", 16'(wr_count),  16'd1);

    // BZ not taken
    clearMem();
    imem[0] = 16'h2000;
    imem[1] = 16'h9040;
    runFresh();
    waitHalt(40);
    checkOutput("bz_fall_pc", 16'(imem_addr), 16'h02);

    // BC taken after an ADD that carries
    clearMem();
    imem[0] = 16'h0000;
    cmem[0] = 1'b1;
    imem[1] = 16'hA020;
    runFresh();
    waitHalt(40);
    checkOutput("bc_taken_pc", 16'(imem_addr), 16'h20);

    // JMP to 0xFF, stalled LDI there, PC wraps to 0x00
    clearMem();
    imem[0]    = 16'hB0FF;
    imem[255]  = 16'h8A5C;
    fetch_wait = 3;
    runFresh();
    waitFetchAt(8'hFF, 60);
    imem[0] = 16'hF000;
    waitHalt(100);
    fetch_wait = 0;
    checkOutput("wrap_halt_pc", 16'(imem_addr),    16'h00);
    checkOutput("wrap_rd_held", 16'(rd_ff_count),  16'd4);
    checkOutput("ldi_wr_addr",  16'(last_wr_addr), 16'd5);
    checkOutput("ldi_wr_sel",   16'(last_wr_sel),  16'd1);
    checkOutput("ldi_imm",      16'(last_imm),     16'h5C);
    checkOutput("ldi_wr_count", 16'(wr_count),     16'd1);

    // HALT then restart clears flags and refetches from 0x00
    clearMem();
    imem[0] = 16'h0000;
    zmem[0] = 1'b1;
    cmem[0] = 1'b1;
    imem[1] = 16'hB005;
    runFresh();
    waitHalt(40);
    checkOutput("halt_pc",    16'(imem_addr), 16'h05);
    checkOutput("halt_busy",  16'(busy),      16'd0);
    checkOutput("halt_flags", 16'({flag_z, flag_c}), 16'h3);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("restart_pc",    16'(imem_addr), 16'h00);
    checkOutput("restart_rd",    16'(imem_rd),   16'd1);
    checkOutput("restart_flags", 16'({flag_z, flag_c}), 16'd0);
    waitHalt(40);

    // Reset while a fetch is stalled
    clearMem();
    imem[0]    = 16'h0000;
    zmem[0]    = 1'b1;
    cmem[0]    = 1'b1;
    block_addr = 1;
    runFresh();
    waitFetchAt(8'h01, 40);
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_flags", 16'({flag_z, flag_c}), 16'h3);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("midrst_busy",  16'(busy),      16'd0);
    checkOutput("midrst_rd",    16'(imem_rd),   16'd0);
    checkOutput("midrst_pc",    16'(imem_addr), 16'h00);
    checkOutput("midrst_flags", 16'({flag_z, flag_c}), 16'd0);
    block_addr = -1;

    // Reserved opcode
    clearMem();
    imem[0] = 16'hC000;
    runFresh();
    waitHalt(40);
`ifdef CPU_CTRL_TRAP_EN
    checkOutput("trap_pc",      16'(imem_addr),  16'h00);
    checkOutput("trap_illegal", 16'(illegal_op), 16'd1);
    imem[0] = 16'hF000;
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("trap_cleared", 16'(illegal_op), 16'd0);
    waitHalt(40);
`else
    checkOutput("nop_pc", 16'(imem_addr), 16'h01);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Multi-cycle control sequencer sitting directly upstream of the 8-bit ALU in the Project 4 CPU. It performs fetch, decode, execute and writeback. It drives the ALU's 3-bit OpCode and the register-file addresses and enables. It consumes the ALU's zero/carry outputs into an architectural flag register used by conditional branches.

Parameters:
PC_W, 8, program counter / instruction address width
INSTR_W, 16, instruction width (fixed field map below; only 16 supported)
RESET_PC, 8'h00, PC value after reset and on restart

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins execution from IDLE or HALT
imem_addr  out  PC_W  instruction address (= PC)
imem_rd  out  1  fetch request, held until imem_valid
imem_data  in  16  instruction word, sampled when imem_valid=1
imem_valid  in  1  fetch acknowledge
rf_ra_addr  out  3  register read port A address (to ALU RdDataA)
rf_rb_addr  out  3  register read port B address (to ALU RdDataB)
rf_wr_addr  out  3  register write address
rf_wr_en  out  1  register write strobe, one cycle
rf_wr_sel  out  1  0 = ALU result, 1 = immediate
imm_out  out  8  immediate for LDI
alu_opcode  out  3  to ALU OpCode
alu_zero  in  1  from ALU zero
alu_carry  in  1  from ALU carry
flag_z  out  1  architectural zero flag
flag_c  out  1  architectural carry flag
busy  out  1  high in any state except IDLE/HALT
halted  out  1  high in HALT

Behaviour:
- Clock/reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset (sync, any state, including mid-fetch): state=IDLE, PC=RESET_PC, flag_z=0, flag_c=0. All outputs 0 except imem_addr=RESET_PC.
- Instruction fields: [15:12] op; [11:9] rd; [8:6] ra; [5:3] rb; [7:0] imm8.
- op 0xxx: ALU op. alu_opcode=op[2:0], writes rd.
- op 1000: LDI, rd <= imm8.
- op 1001: BZ, PC <= imm8 if flag_z.
- op 1010: BC, PC <= imm8 if flag_c.
- op 1011: JMP, PC <= imm8.
- op 1111: HALT.
- op 1100-1110: reserved.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: imem_rd=1, imem_addr=PC. On imem_valid=1, latch IR and go to DECODE. Otherwise wait indefinitely; imem_rd stays high.
- DECODE: drive rf_ra_addr/rf_rb_addr/alu_opcode from IR. These stay stable through EXEC and WB. Always -> EXEC.
- EXEC, ALU op:
  - flag_z <= alu_zero.
  - flag_c <= alu_carry only for op 000/001; otherwise flag_c holds.
  - -> WB.
- EXEC, LDI: -> WB.
- EXEC, branch/JMP: PC <= target if taken, else PC+1. -> FETCH. No WB.
- EXEC, HALT: -> HALT. PC holds pointing at the HALT instruction.
- EXEC, reserved op: NOP. PC+1 -> FETCH.
- WB: rf_wr_en=1 for exactly one cycle; rf_wr_addr=rd; rf_wr_sel=1 for LDI, else 0. PC <= PC+1. -> FETCH.
- Latency with zero-wait fetch (imem_valid in the first FETCH cycle): ALU/LDI = 4 cycles per instruction; branch = 3 cycles.
- PC arithmetic: modulo 2^PC_W; 8'hFF+1 wraps to 8'h00.
- Branch flags: branches read the flags as updated by the previous instruction. The flags are never written by LDI or branches.
- HALT: start=1 -> PC=RESET_PC, flags cleared, -> FETCH.
- start while busy is ignored.
- imem_valid outside FETCH is ignored.

Optional Feature:
- Macro: CPU_CTRL_TRAP_EN.
- Defined: reserved ops 1100-1110 go EXEC -> HALT; extra output illegal_op (1 bit) is set in HALT; PC holds at the offending instruction. illegal_op is cleared by rst or start.
- Undefined: reserved ops are NOPs; port illegal_op is absent.

Decomposition:
- Shared package cpu_pkg holds:
  - op encoding localparams (OP_LDI, OP_BZ, OP_BC, OP_JMP, OP_HALT);
  - ALU opcode constants 000-111;
  - state encoding;
  - instruction field bit positions.
- One sub-module is natural: cpu_pc. It holds the PC register with load, increment and wrap, plus RESET_PC restart.

Test Plan:
- Reset mid-fetch: rst during FETCH with imem_valid=0 -> next cycle state IDLE, imem_rd=0, PC=00, flags 0.
- ADD with carry: R1=8'hF0, R2=8'h20, instr 16'h0288 (ADD rd=1, ra=2, rb=1). ALU returns zero=0, carry=1 -> flag_c=1, flag_z=0. rf_wr_en pulses once with addr 1; 4 cycles total.
- Carry hold: SUB sets flag_c=1, then an AND with alu_carry=0 -> flag_c stays 1; flag_z follows alu_zero.
- BZ: flag_z=1, instr 16'h9040 -> PC=8'h40 with no rf_wr_en. With flag_z=0 -> PC=old+1.
- Wrap and fetch stall: PC=8'hFF with an LDI and imem_valid delayed 3 cycles -> imem_rd held 3 cycles, then PC=8'h00.
- HALT/restart: 16'hF000 -> halted=1, busy=0, start ignored until state is HALT; then start -> fetch at 8'h00. With CPU_CTRL_TRAP_EN, 16'hC000 -> halted=1, illegal_op=1.
